// File: rtl/door_dwell_timer.sv
// Door-dwell timer: times the open-door dwell with a prescaled step counter,
// restarts on door re-open (hold), enters nudge mode once re-opens run out,
// and supports early close and abort from the main elevator FSM.
module door_dwell_timer #(
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned DEFAULT_DWELL = 5,
    parameter int unsigned PRESCALE      = 1,
    parameter int unsigned MAX_REOPEN    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] dwell_len,
    input  logic             hold,
    input  logic             close_req,
    input  logic             abort,
    output logic             busy,
    output logic             wait_complete,
    output logic [CNT_W-1:0] count,
    output logic             nudge,
    output logic [1:0]       state
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned RO_W = (MAX_REOPEN > 0) ? $clog2(MAX_REOPEN + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           st;
    logic [PS_W-1:0]  ps;
    logic [RO_W-1:0]  reopen;
    logic [CNT_W-1:0] target;
    logic             tick_c;
    logic             last_c;
    logic             can_reopen_c;

    // Step strobe, final-step detect and remaining re-open budget
    assign tick_c       = (ps == PS_W'(PRESCALE - 1));
    assign last_c       = (count == target - CNT_W'(1));
    assign can_reopen_c = (reopen < RO_W'(MAX_REOPEN));

    assign state = st;

    // Dwell FSM with prescaler, step counter and re-open bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st            <= IDLE;
            busy          <= 1'b0;
            wait_complete <= 1'b0;
            count         <= '0;
            nudge         <= 1'b0;
            ps            <= '0;
            reopen        <= '0;
            target        <= '0;
        end else begin
            wait_complete <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        st     <= DWELL;
                        busy   <= 1'b1;
                        target <= (dwell_len == '0) ? CNT_W'(DEFAULT_DWELL) : dwell_len;
                        count  <= '0;
                        ps     <= '0;
                        reopen <= '0;
                        nudge  <= 1'b0;
                    end
                end
                DWELL: begin
                    if (abort) begin
                        st     <= IDLE;
                        busy   <= 1'b0;
                        count  <= '0;
                        ps     <= '0;
                        reopen <= '0;
                        nudge  <= 1'b0;
                    end else if (hold && can_reopen_c) begin
                        st     <= HOLD;
                        count  <= '0;
                        ps     <= '0;
                        reopen <= reopen + RO_W'(1);
                    end else begin
                        // Exhausted re-opens: hold no longer restarts, flag nudge
                        if (hold) begin
                            nudge <= 1'b1;
                        end
                        if (close_req || (tick_c && last_c)) begin
                            wait_complete <= 1'b1;
                            st            <= IDLE;
                            busy          <= 1'b0;
                            count         <= '0;
                            ps            <= '0;
                            reopen        <= '0;
                            nudge         <= 1'b0;
                        end else if (tick_c) begin
                            ps    <= '0;
                            count <= count + CNT_W'(1);
                        end else begin
                            ps <= ps + PS_W'(1);
                        end
                    end
                end
                HOLD: begin
                    count <= '0;
                    ps    <= '0;
                    if (abort) begin
                        st     <= IDLE;
                        busy   <= 1'b0;
                        reopen <= '0;
                        nudge  <= 1'b0;
                    end else if (!hold) begin
                        st <= DWELL;
                    end
                end
                default: begin
                    st     <= IDLE;
                    busy   <= 1'b0;
                    count  <= '0;
                    ps     <= '0;
                    reopen <= '0;
                    nudge  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_door_dwell_timer.sv
// Bench for door_dwell_timer: two builds (prescale 1 and prescale 4) driven by
// shared directed and random stimulus, compared every cycle against an
// elapsed-cycle reference model.
module tb_door_dwell_timer;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] dwell_len;
    logic             hold;
    logic             close_req;
    logic             abort;

    logic             u0_busy, u0_wc, u0_nudge;
    logic [CNT_W-1:0] u0_count;
    logic [1:0]       u0_state;
    logic             u1_busy, u1_wc, u1_nudge;
    logic [CNT_W-1:0] u1_count;
    logic [1:0]       u1_state;

    int checks = 0;
    int errors = 0;

    // Per-build parameters mirrored for the model
    int p_pre [2] = '{1, 4};
    int p_def [2] = '{5, 3};
    int p_maxr[2] = '{2, 1};

    // Model: a dwell is "elapsed cycles since (re)start"; it finishes when
    // elapsed reaches target*prescale, and count is elapsed/prescale.
    bit m_act  [2];
    bit m_held [2];
    bit m_nudge[2];
    bit m_pulse[2];
    int m_el   [2];
    int m_tgt  [2];
    int m_ro   [2];

    always #5 clk = ~clk;

    door_dwell_timer #(.CNT_W(CNT_W), .DEFAULT_DWELL(5), .PRESCALE(1), .MAX_REOPEN(2)) u0 (
        .clk(clk), .rst(rst), .start(start), .dwell_len(dwell_len), .hold(hold),
        .close_req(close_req), .abort(abort), .busy(u0_busy), .wait_complete(u0_wc),
        .count(u0_count), .nudge(u0_nudge), .state(u0_state)
    );

    door_dwell_timer #(.CNT_W(CNT_W), .DEFAULT_DWELL(3), .PRESCALE(4), .MAX_REOPEN(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .dwell_len(dwell_len), .hold(hold),
        .close_req(close_req), .abort(abort), .busy(u1_busy), .wait_complete(u1_wc),
        .count(u1_count), .nudge(u1_nudge), .state(u1_state)
    );

    task automatic model_idle(input int k);
        m_act[k]   = 1'b0;
        m_held[k]  = 1'b0;
        m_el[k]    = 0;
        m_ro[k]    = 0;
        m_nudge[k] = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            model_idle(k);
            m_pulse[k] = 1'b0;
            m_tgt[k]   = 0;
        end
    endtask

    task automatic model_step(input int k);
        m_pulse[k] = 1'b0;
        if (!m_act[k]) begin
            if (start) begin
                m_act[k]   = 1'b1;
                m_held[k]  = 1'b0;
                m_el[k]    = 0;
                m_ro[k]    = 0;
                m_nudge[k] = 1'b0;
                m_tgt[k]   = (dwell_len == 0) ? p_def[k] : int'(dwell_len);
            end
        end else if (abort) begin
            model_idle(k);
        end else if (m_held[k]) begin
            if (!hold) begin
                m_held[k] = 1'b0;
                m_el[k]   = 0;
            end
        end else if (hold && m_ro[k] < p_maxr[k]) begin
            m_held[k] = 1'b1;
            m_el[k]   = 0;
            m_ro[k]   = m_ro[k] + 1;
        end else begin
            if (hold) m_nudge[k] = 1'b1;
            if (close_req) begin
                m_pulse[k] = 1'b1;
                model_idle(k);
            end else begin
                m_el[k] = m_el[k] + 1;
                if (m_el[k] == m_tgt[k] * p_pre[k]) begin
                    m_pulse[k] = 1'b1;
                    model_idle(k);
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        int ecount[2];
        int estate[2];
        for (int k = 0; k < 2; k++) begin
            ecount[k] = (m_act[k] && !m_held[k]) ? m_el[k] / p_pre[k] : 0;
            estate[k] = !m_act[k] ? 0 : (m_held[k] ? 2 : 1);
        end
        check("u0.busy",  32'(u0_busy),  32'(m_act[0]));
        check("u0.wc",    32'(u0_wc),    32'(m_pulse[0]));
        check("u0.count", 32'(u0_count), 32'(ecount[0]));
        check("u0.nudge", 32'(u0_nudge), 32'(m_nudge[0]));
        check("u0.state", 32'(u0_state), 32'(estate[0]));
        check("u1.busy",  32'(u1_busy),  32'(m_act[1]));
        check("u1.wc",    32'(u1_wc),    32'(m_pulse[1]));
        check("u1.count", 32'(u1_count), 32'(ecount[1]));
        check("u1.nudge", 32'(u1_nudge), 32'(m_nudge[1]));
        check("u1.state", 32'(u1_state), 32'(estate[1]));
    endtask

    // One clock: model advances on the edge, outputs sampled 1 time unit later
    task automatic step(input logic s, input logic h, input logic c, input logic a);
        start     = s;
        hold      = h;
        close_req = c;
        abort     = a;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            model_step(0);
            model_step(1);
        end
        #1;
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        dwell_len = '0;
        hold      = 1'b0;
        close_req = 1'b0;
        abort     = 1'b0;
        model_reset();

        // Reset state, including start/hold ignored while in reset
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycles(1);
        rst = 1'b1;
        idle_cycles(2);

        // Default dwell (dwell_len=0)
        dwell_len = 8'd0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(16);

        // Programmed dwell of 3 steps; dwell_len changes mid-dwell are ignored
        dwell_len = 8'd3;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        dwell_len = 8'd1;
        idle_cycles(15);

        // Target of one step completes on the first tick
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(6);

        // Hold for 4 cycles at count 3, then full restart
        dwell_len = 8'd0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(14);

        // Three hold pulses in one dwell: re-opens run out, nudge, completion
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            idle_cycles(2);
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end
        idle_cycles(16);

        // close_req at count 2
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles(2);

        // close_req together with hold enters HOLD, no pulse; close held in HOLD ignored
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        idle_cycles(14);

        // Start and hold together in IDLE: start accepted, hold seen next cycle
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(14);

        // Abort at count 3
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycles(3);

        // Asynchronous reset between edges at count 2
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b1;
        idle_cycles(8);

        // Randomised traffic, including dwell_len changes and long holds
        for (int i = 0; i < 1500; i++) begin
            dwell_len = CNT_W'($urandom_range(0, 6));
            step(1'b0 | ($urandom_range(0, 99) < 30),
                 1'b0 | ($urandom_range(0, 99) < 12),
                 1'b0 | ($urandom_range(0, 99) < 4),
                 1'b0 | ($urandom_range(0, 99) < 3));
        end
        idle_cycles(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
